// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the multicycle MIPS controller (master) and its datapath (slave).
interface mips_multicycle_ctrl_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic       pcen;
    logic [2:0] alucontrol;
    logic [3:0] state;
    logic       illegal;

    modport master (
        input  op, funct, zero, mem_ready,
        output iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc,
               pcen, alucontrol, state, illegal
    );

    modport slave (
        output op, funct, zero, mem_ready,
        input  iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca, alusrcb, pcsrc,
               pcen, alucontrol, state, illegal
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main controller: sequences fetch/decode/execute/memory/writeback over a shared
// memory port, with registered per-state controls gated by mem_ready, branch outcome and reset.
module mips_multicycle_ctrl #(
    parameter bit USE_MEM_READY = 1'b0,
    parameter bit EN_BNE        = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_multicycle_ctrl_if.master bus
);

    typedef enum logic [3:0] {
        StFetch   = 4'd0,
        StDecode  = 4'd1,
        StMemAdr  = 4'd2,
        StMemRd   = 4'd3,
        StMemWb   = 4'd4,
        StMemWr   = 4'd5,
        StExecute = 4'd6,
        StAluWb   = 4'd7,
        StBranch  = 4'd8,
        StAddiEx  = 4'd9,
        StAddiWb  = 4'd10,
        StJump    = 4'd11
    } state_e;

    typedef struct packed {
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       regdst;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsrc;
        logic [1:0] aluop;
        logic       pcwrite;
        logic       branch;
    } ctrl_t;

    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // Moore control word for a state; irwrite/pcwrite here are pre-mem_ready-gating.
    function automatic ctrl_t decode(state_e s);
        ctrl_t c;
        c = '0;
        case (s)
            StFetch:   begin c.alusrcb = 2'b01; c.irwrite = 1'b1; c.pcwrite = 1'b1; end
            StDecode:  c.alusrcb = 2'b11;
            StMemAdr:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            StMemRd:   c.iord = 1'b1;
            StMemWb:   begin c.memtoreg = 1'b1; c.regwrite = 1'b1; end
            StMemWr:   begin c.iord = 1'b1; c.memwrite = 1'b1; end
            StExecute: begin c.alusrca = 1'b1; c.aluop = 2'b10; end
            StAluWb:   begin c.regdst = 1'b1; c.regwrite = 1'b1; end
            StBranch:  begin
                c.alusrca = 1'b1;
                c.aluop   = 2'b01;
                c.pcsrc   = 2'b01;
                c.branch  = 1'b1;
            end
            StAddiEx:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
            StAddiWb:  c.regwrite = 1'b1;
            StJump:    begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
            default:   c = '0;
        endcase
        return c;
    endfunction

    state_e state_q, state_d;
    ctrl_t  ctrl_q;
    logic   mr;
    logic   is_bne;
    logic   funct_ok;
    logic   illegal_dec;

    assign mr     = USE_MEM_READY ? bus.mem_ready : 1'b1;
    assign is_bne = EN_BNE && (bus.op == OpBne);

    always_comb begin
        unique case (bus.funct)
            6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: funct_ok = 1'b1;
            default:                                               funct_ok = 1'b0;
        endcase
    end

    always_comb begin
        state_d     = StFetch;
        illegal_dec = 1'b0;
        case (state_q)
            StFetch:   state_d = mr ? StDecode : StFetch;
            StDecode: begin
                case (bus.op)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    if (funct_ok) state_d = StExecute; else illegal_dec = 1'b1;
                    OpBeq:      state_d = StBranch;
                    OpBne:      if (EN_BNE) state_d = StBranch; else illegal_dec = 1'b1;
                    OpAddi:     state_d = StAddiEx;
                    OpJ:        state_d = StJump;
                    default:    illegal_dec = 1'b1;
                endcase
            end
            StMemAdr:  state_d = (bus.op == OpLw) ? StMemRd : StMemWr;
            StMemRd:   state_d = mr ? StMemWb : StMemRd;
            StMemWr:   state_d = mr ? StFetch : StMemWr;
            StExecute: state_d = StAluWb;
            StAddiEx:  state_d = StAddiWb;
            default:   state_d = StFetch;
        endcase
    end

    // Reset preloads the FETCH word so the first cycle after release already drives fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StFetch;
            ctrl_q  <= decode(StFetch);
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d);
        end
    end

    always_comb begin
        bus.iord       = 1'b0;
        bus.memwrite   = 1'b0;
        bus.irwrite    = 1'b0;
        bus.regdst     = 1'b0;
        bus.memtoreg   = 1'b0;
        bus.regwrite   = 1'b0;
        bus.alusrca    = 1'b0;
        bus.alusrcb    = 2'b00;
        bus.pcsrc      = 2'b00;
        bus.pcen       = 1'b0;
        bus.alucontrol = 3'b000;
        bus.illegal    = 1'b0;
        bus.state      = state_q;
        if (!reset) begin
            bus.iord     = ctrl_q.iord;
            bus.memwrite = ctrl_q.memwrite;
            bus.irwrite  = ctrl_q.irwrite & mr;
            bus.regdst   = ctrl_q.regdst;
            bus.memtoreg = ctrl_q.memtoreg;
            bus.regwrite = ctrl_q.regwrite;
            bus.alusrca  = ctrl_q.alusrca;
            bus.alusrcb  = ctrl_q.alusrcb;
            bus.pcsrc    = ctrl_q.pcsrc;
            bus.illegal  = illegal_dec;
            // Only the fetch-time PC write waits for memory; JUMP writes unconditionally.
            bus.pcen = (ctrl_q.pcwrite & ((state_q != StFetch) | mr))
                     | (ctrl_q.branch & (is_bne ? ~bus.zero : bus.zero));
            case (ctrl_q.aluop)
                2'b01:   bus.alucontrol = 3'b110;
                2'b10: begin
                    case (bus.funct)
                        6'b100010: bus.alucontrol = 3'b110;
                        6'b100100: bus.alucontrol = 3'b000;
                        6'b100101: bus.alucontrol = 3'b001;
                        6'b101010: bus.alucontrol = 3'b111;
                        default:   bus.alucontrol = 3'b010;
                    endcase
                end
                default: bus.alucontrol = 3'b010;
            endcase
        end
    end

endmodule
